// File: rtl/nes_pad_poller.sv
// NES game-pad poller: periodically latches the pad, shifts in the eight button bits
// and publishes them as controller_data, raising a level interrupt held until acknowledged.
module nes_pad_poller #(
    parameter int unsigned POLL_PERIOD = 416667,
    parameter int unsigned HALF_BIT    = 150,
    parameter bit          INT_ON_ALL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    output logic       latch_out,
    output logic       clk_out,
    output logic [7:0] controller_data,
    output logic       int_out,
    input  logic       int_ack,
    output logic       busy
);

    localparam int unsigned CW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int unsigned PW = $clog2(2 * HALF_BIT);

    localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_PERIOD - 1);
    localparam logic [PW-1:0] UNIT_LAST  = PW'(HALF_BIT - 1);
    localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LATCH  = 3'd1;
    localparam logic [2:0] S_WAIT0  = 3'd2;
    localparam logic [2:0] S_CLK_HI = 3'd3;
    localparam logic [2:0] S_CLK_LO = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [CW-1:0] poll_cnt;
    logic          poll_tick;
    logic [1:0]    sync_q;
    logic          sample;
    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [PW-1:0] phase;
    logic          phase_clr;
    logic          sample_en;
    logic          unit_end;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          int_set;

    // NOTE: reset value is 1 so an idle (released) data line reads as "not pressed".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], data_in};
        end
    end

    assign sample = ~sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_cnt <= '0;
        end else if (poll_tick) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    assign poll_tick = (poll_cnt == POLL_LAST);
    assign unit_end  = (phase == UNIT_LAST);

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        next_state = state;
        phase_clr  = 1'b0;
        sample_en  = 1'b0;
        case (state)
            S_IDLE: begin
                if (poll_tick) begin
                    next_state = S_LATCH;
                    phase_clr  = 1'b1;
                end
            end
            S_LATCH: begin
                if (phase == LATCH_LAST) begin
                    next_state = S_WAIT0;
                    phase_clr  = 1'b1;
                end
            end
            S_WAIT0: begin
                if (unit_end) begin
                    next_state = S_CLK_HI;
                    phase_clr  = 1'b1;
                    sample_en  = 1'b1;
                end
            end
            S_CLK_HI: begin
                if (unit_end) begin
                    next_state = S_CLK_LO;
                    phase_clr  = 1'b1;
                end
            end
            S_CLK_LO: begin
                if (unit_end) begin
                    next_state = (bit_idx == 3'd7) ? S_DONE : S_CLK_HI;
                    phase_clr  = 1'b1;
                    sample_en  = 1'b1;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
                phase_clr  = 1'b1;
            end
            default: begin
                next_state = S_IDLE;
                phase_clr  = 1'b1;
            end
        endcase
    end

    assign int_set = (state == S_DONE) && (INT_ON_ALL || (shreg != controller_data));

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            phase     <= '0;
            latch_out <= 1'b0;
            clk_out   <= 1'b0;
        end else begin
            state     <= next_state;
            phase     <= (phase_clr || state == S_IDLE) ? '0 : phase + 1'b1;
            latch_out <= (next_state == S_LATCH);
            clk_out   <= (next_state == S_CLK_HI);
        end
    end

    // bit_idx is zeroed at frame start so WAIT0 lands the first bit in shreg[0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == S_IDLE && poll_tick) begin
                bit_idx <= '0;
            end else if (sample_en && bit_idx != 3'd7) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (sample_en) begin
                shreg[bit_idx] <= sample;
            end
        end
    end

    // A new interrupt in DONE wins over a simultaneous acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            controller_data <= '0;
            int_out         <= 1'b0;
        end else begin
            if (state == S_DONE) begin
                controller_data <= shreg;
            end
            if (int_set) begin
                int_out <= 1'b1;
            end else if (int_ack) begin
                int_out <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_nes_pad_poller.sv
// Directed bench for nes_pad_poller with a behavioural pad model
// (load while latch is high, shift on clk_out rise); cycle N = N rising edges after reset release.
module tb_nes_pad_poller;

    localparam int unsigned POLL = 200;
    localparam int unsigned HB   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_in;
    logic       latch_out;
    logic       clk_out;
    logic [7:0] controller_data;
    logic       int_out;
    logic       int_ack;
    logic       busy;

    logic       latch_all;
    logic       clk_out_all;
    logic [7:0] data_all;
    logic       int_all;
    logic       int_ack_all;
    logic       busy_all;

    logic [7:0] pad_btn;
    logic [7:0] pad_sr = 8'h00;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int clk_rises, latch_rises, busy_cycles;
    logic prev_clk, prev_latch;

    always #5 clk = ~clk;

    nes_pad_poller #(.POLL_PERIOD(POLL), .HALF_BIT(HB), .INT_ON_ALL(1'b0)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .latch_out(latch_out), .clk_out(clk_out),
        .controller_data(controller_data), .int_out(int_out), .int_ack(int_ack), .busy(busy)
    );

    nes_pad_poller #(.POLL_PERIOD(POLL), .HALF_BIT(HB), .INT_ON_ALL(1'b1)) dut_all (
        .clk(clk), .rst(rst), .data_in(1'b1), .latch_out(latch_all), .clk_out(clk_out_all),
        .controller_data(data_all), .int_out(int_all), .int_ack(int_ack_all), .busy(busy_all)
    );

    // Pad: pressed buttons drive the data line low; empty shift positions read released.
    assign data_in = ~pad_sr[0];
    always @(posedge latch_out or posedge clk_out) begin
        if (latch_out) pad_sr <= pad_btn;
        else           pad_sr <= {1'b0, pad_sr[7:1]};
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_n(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        clk_rises   = 0;
        latch_rises = 0;
        busy_cycles = 0;
        prev_clk    = clk_out;
        prev_latch  = latch_out;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (clk_out && !prev_clk) clk_rises++;
        if (latch_out && !prev_latch) latch_rises++;
        if (busy) busy_cycles++;
        prev_clk   = clk_out;
        prev_latch = latch_out;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        int_ack     = 1'b0;
        int_ack_all = 1'b0;
        pad_btn     = 8'h09;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_latch", latch_out, 1'b0);
        check1("rst_clk_out", clk_out, 1'b0);
        check1("rst_int", int_out, 1'b0);
        check8("rst_data", controller_data, 8'h00);
        check1("rst_busy", busy, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        clear_counts();

        // Frame 1: A+Start
        go_to(199); check1("f1_latch_199", latch_out, 1'b0); check1("f1_busy_199", busy, 1'b0);
        go_to(200); check1("f1_latch_200", latch_out, 1'b1); check1("f1_busy_200", busy, 1'b1);
        go_to(207); check1("f1_latch_207", latch_out, 1'b1);
        go_to(208); check1("f1_latch_208", latch_out, 1'b0);
        go_to(211); check1("f1_clk_211", clk_out, 1'b0);
        go_to(212); check1("f1_clk_212", clk_out, 1'b1);
        go_to(216); check1("f1_clk_216", clk_out, 1'b0);
        go_to(268); check8("f1_data_268", controller_data, 8'h00); check1("f1_busy_268", busy, 1'b1);
        go_to(269);
        check8("f1_data_269", controller_data, 8'h09);
        check1("f1_int_269", int_out, 1'b1);
        check1("f1_busy_269", busy, 1'b0);
        check_n("f1_clk_rises", clk_rises, 7);
        check_n("f1_latch_rises", latch_rises, 1);
        check_n("f1_busy_cycles", busy_cycles, 69);

        // Frame 2: same byte, interrupt acknowledged beforehand
        go_to(270);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        check1("f2_int_acked", int_out, 1'b0);
        clear_counts();
        go_to(469);
        check8("f2_data", controller_data, 8'h09);
        check1("f2_int", int_out, 1'b0);
        check_n("f2_clk_rises", clk_rises, 7);
        check_n("f2_latch_rises", latch_rises, 1);
        check_n("f2_busy_cycles", busy_cycles, 69);

        // Frame 3: Right only, ack coincides with DONE
        pad_btn = 8'h80;
        go_to(668);
        check1("f3_busy_done", busy, 1'b1);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        check8("f3_data", controller_data, 8'h80);
        check1("f3_int_set_wins", int_out, 1'b1);
        step();
        check1("f3_int_held", int_out, 1'b1);

        // Frame 4: reset during CLK_HI of bit 4
        go_to(837);
        check1("f4_clk_hi", clk_out, 1'b1);
        #1 rst = 1'b1;
        #1;
        check1("f4_rst_clk_out", clk_out, 1'b0);
        check1("f4_rst_latch", latch_out, 1'b0);
        check1("f4_rst_int", int_out, 1'b0);
        check8("f4_rst_data", controller_data, 8'h00);
        check1("f4_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        clear_counts();
        go_to(199); check1("f4_latch_199", latch_out, 1'b0);
        go_to(200); check1("f4_latch_200", latch_out, 1'b1);

        // Pad absent on the INT_ON_ALL instance; pressed-Right frame on the other
        go_to(269);
        check8("f5_all_data_1", data_all, 8'h00);
        check1("f5_all_int_1", int_all, 1'b1);
        check8("f5_data_after_rst", controller_data, 8'h80);
        check1("f5_int_after_rst", int_out, 1'b1);
        go_to(270);
        int_ack_all = 1'b1;
        step();
        int_ack_all = 1'b0;
        check1("f5_all_int_acked", int_all, 1'b0);
        go_to(468);
        check1("f5_all_int_468", int_all, 1'b0);
        go_to(469);
        check8("f5_all_data_2", data_all, 8'h00);
        check1("f5_all_int_2", int_all, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
